// File: rtl/roce_rnr_retry_timer.sv
// roce_rnr_retry_timer
// RNR back-off and retry controller for one RC queue pair. An RNR NAK loads
// the IB RNR wait time (in NET_CLOCK cycles, 4.0 ns period) selected by the
// AETH timer code. The controller counts that time down, then issues one
// valid/ready retry request carrying the PSN to resend. Completed retries are
// counted against the QP's RNR retry limit. Exhausting the limit raises a
// sticky rnr_error.
//
// Build option:
//   RNR_TIMER_SIM_SCALE_EN  When defined, loaded wait = table value >> 10.
//                           This shortens simulation only.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   s_rnr_nak_valid/_timer_code/_psn
//                               RNR NAK pulse with AETH timer code and PSN
//   cfg_rnr_retry_limit         retry limit; all-ones = infinite
//   cancel                      positive ACK / QP close; aborts and clears
//   m_retry_valid/_ready/_psn   retry request handshake to the TX requester
//   busy                        back-off or retry pending; requester holds TX
//   rnr_error                   retries exhausted (sticky until cancel)
//   retry_count                 retries completed since last cancel
module roce_rnr_retry_timer #(
  parameter int PSN_WIDTH       = 24,
  parameter int RETRY_CNT_WIDTH = 3,
  parameter int TIMER_WIDTH     = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_rnr_nak_valid,
  input  logic [4:0]                 s_rnr_nak_timer_code,
  input  logic [PSN_WIDTH-1:0]       s_rnr_nak_psn,
  input  logic [RETRY_CNT_WIDTH-1:0] cfg_rnr_retry_limit,
  input  logic                       cancel,
  output logic                       m_retry_valid,
  input  logic                       m_retry_ready,
  output logic [PSN_WIDTH-1:0]       m_retry_psn,
  output logic                       busy,
  output logic                       rnr_error,
  output logic [RETRY_CNT_WIDTH-1:0] retry_count
);

  typedef enum logic [1:0] {IDLE, WAIT, REQ, ERROR} state_t;

  localparam logic [RETRY_CNT_WIDTH-1:0] CNT_MAX = '1;

  // RNR_TIMER_VALUES in 4 ns cycles. Code 0 is the longest wait (655.36 ms).
  // Codes 1..31 ascend from 0.01 ms.
  function automatic logic [31:0] rnr_timer_value(input logic [4:0] code);
    logic [31:0] v;
    case (code)
      5'd0:  v = 32'd163840000;
      5'd1:  v = 32'd2500;
      5'd2:  v = 32'd5000;
      5'd3:  v = 32'd7500;
      5'd4:  v = 32'd10000;
      5'd5:  v = 32'd15000;
      5'd6:  v = 32'd20000;
      5'd7:  v = 32'd30000;
      5'd8:  v = 32'd40000;
      5'd9:  v = 32'd60000;
      5'd10: v = 32'd80000;
      5'd11: v = 32'd120000;
      5'd12: v = 32'd160000;
      5'd13: v = 32'd240000;
      5'd14: v = 32'd320000;
      5'd15: v = 32'd480000;
      5'd16: v = 32'd640000;
      5'd17: v = 32'd960000;
      5'd18: v = 32'd1280000;
      5'd19: v = 32'd1920000;
      5'd20: v = 32'd2560000;
      5'd21: v = 32'd3840000;
      5'd22: v = 32'd5120000;
      5'd23: v = 32'd7680000;
      5'd24: v = 32'd10240000;
      5'd25: v = 32'd15360000;
      5'd26: v = 32'd20480000;
      5'd27: v = 32'd30720000;
      5'd28: v = 32'd40960000;
      5'd29: v = 32'd61440000;
      5'd30: v = 32'd81920000;
      default: v = 32'd122880000;
    endcase
`ifdef RNR_TIMER_SIM_SCALE_EN
    return v >> 10;
`else
    return v;
`endif
  endfunction

  state_t                     state_q, state_d;
  logic [TIMER_WIDTH-1:0]     timer_q, timer_d;
  logic [PSN_WIDTH-1:0]       psn_d;
  logic [RETRY_CNT_WIDTH-1:0] cnt_d;
  logic [TIMER_WIDTH-1:0]     load_val;
  logic                       limit_hit;

  assign load_val  = TIMER_WIDTH'(rnr_timer_value(s_rnr_nak_timer_code));
  assign limit_hit = (cfg_rnr_retry_limit != CNT_MAX) &&
                     (retry_count == cfg_rnr_retry_limit);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    psn_d   = m_retry_psn;
    cnt_d   = retry_count;
    if (cancel) begin
      state_d = IDLE;
      timer_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (s_rnr_nak_valid) begin
          if (limit_hit) begin
            state_d = ERROR;
          end else begin
            state_d = WAIT;
            timer_d = load_val;
            psn_d   = s_rnr_nak_psn;
          end
        end
        WAIT: begin
          // A fresh NAK restarts the back-off.
          // This takes priority over expiry in the same cycle.
          if (s_rnr_nak_valid) begin
            timer_d = load_val;
            psn_d   = s_rnr_nak_psn;
          end else if (timer_q == '0) begin
            state_d = REQ;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        // m_retry_valid is high exactly while in REQ, so ready alone completes the handshake.
        REQ: if (m_retry_ready) begin
          state_d = IDLE;
          if (retry_count != CNT_MAX) cnt_d = retry_count + 1'b1;
        end
        default: ;  // ERROR: held until cancel
      endcase
    end
  end

  // Outputs are registered from the next state.
  // This keeps them glitch-free and independent of m_retry_ready within a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      m_retry_psn   <= '0;
      retry_count   <= '0;
      m_retry_valid <= 1'b0;
      busy          <= 1'b0;
      rnr_error     <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      m_retry_psn   <= psn_d;
      retry_count   <= cnt_d;
      m_retry_valid <= (state_d == REQ);
      busy          <= (state_d == WAIT) || (state_d == REQ);
      rnr_error     <= (state_d == ERROR);
    end
  end

endmodule
